// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode and FSM state encodings.
package alu_pkg;

    // Operand/result width; only 8 is supported.
    localparam int ALU_DATA_W = 8;

    // Opcode field as seen on OP.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    // Sequencer states: idle, iterative multiply, one-cycle write-back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } alu_state_e;

    // Number of shift-add steps the multiplier needs for an 8-bit multiplier operand.
    localparam int MUL_STEPS = 8;

endpackage : alu_pkg

// File: rtl/alu_mul8.sv
// Iterative 8x8 unsigned shift-add multiplier: load once, then one multiplier bit per step.
// The next-state product is exported so the caller can capture the final product on the
// same edge as the last step.
module alu_mul8
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] prod_next_o,
    output logic        last_o
);

    logic [15:0] prod_q;
    logic [15:0] prod_d;
    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;

    // Partial-product add for the current multiplier bit and last-step detection.
    always_comb begin
        prod_d = prod_q;
        if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
        end
        prod_next_o = prod_d;
        last_o      = step_i && (cnt_q == 3'(MUL_STEPS - 1));
    end

    // Datapath: clear accumulator on load, otherwise accumulate and shift per step.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            prod_q   <= '0;
            mcand_q  <= {8'd0, a_i};
            mplier_q <= b_i;
        end else if (step_i) begin
            prod_q   <= prod_d;
            mcand_q  <= {mcand_q[14:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[7:1]};
        end
    end

    // Step counter; restarted by every load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

endmodule : alu_mul8

// File: rtl/alu_exec.sv
// Execute-stage ALU with register-file write-back handshake.
// Single-cycle ops write back in the cycle after acceptance; MUL runs eight
// shift-add cycles in alu_mul8 before its write-back cycle. Results and flags
// only change on entry to write-back and are held until the next one.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
)
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] cin_bus_i,
    input  logic [1:0]        dest_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] result_hi_o,
    output logic              zf_o,
    output logic              cf_o,
    output logic              nf_o,
    output logic              vf_o,
    output logic              wb_we_o,
    output logic [1:0]        wb_wa_o
);

    // Single-cycle ALU: returns {cf, vf, result}. MUL is handled by alu_mul8.
    function automatic logic [DATA_W+1:0] alu_compute(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              cin
    );
        logic [DATA_W:0]   wide;
        logic [DATA_W-1:0] res;
        logic              cf;
        logic              vf;
        wide = '0;
        res  = '0;
        cf   = 1'b0;
        vf   = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                res  = wide[DATA_W-1:0];
                cf   = wide[DATA_W];
                // Same-sign operands producing an opposite-sign result overflow.
                vf   = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                // The ninth bit of the zero-extended difference is the borrow.
                wide = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
                res  = wide[DATA_W-1:0];
                cf   = wide[DATA_W];
                vf   = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res = {a[DATA_W-2:0], cin};
                cf  = a[DATA_W-1];
            end
            OP_SHR: begin
                res = {cin, a[DATA_W-1:1]};
                cf  = a[0];
            end
            default: begin
                res = '0;
            end
        endcase
        return {cf, vf, res};
    endfunction

    alu_state_e          state_q;
    alu_state_e          state_d;
    logic                accept;
    logic                is_mul;
    logic                mul_load;
    logic                mul_step;
    logic                mul_last;
    logic                wb_alu;
    logic                wb_mul;
    logic [2*DATA_W-1:0] mul_prod;
    logic [DATA_W+1:0]   alu_out;

    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   result_hi_q;
    logic                zf_q;
    logic                cf_q;
    logic                nf_q;
    logic                vf_q;
    logic [1:0]          dest_q;

    // Only bit 0 of the constant bus is meaningful as carry-in.
    logic                cin_bus_unused;
    assign cin_bus_unused = ^cin_bus_i[DATA_W-1:1];

    assign is_mul  = (op_i == OP_MUL);
    assign accept  = start_i && (state_q == ST_IDLE);
    assign alu_out = alu_compute(op_i, opa_i, opb_i, cin_bus_i[0]);
    assign wb_alu  = accept && !is_mul;
    assign wb_mul  = (state_q == ST_MUL) && mul_last;

    // Next-state and multiplier control; START is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_mul) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        state_d  = ST_WB;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-back address is latched at acceptance and held until the next one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dest_q <= '0;
        end else if (accept) begin
            dest_q <= dest_i;
        end
    end

    // Result and flag registers load only on entry to write-back.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            nf_q        <= 1'b0;
            vf_q        <= 1'b0;
        end else if (wb_alu) begin
            result_q    <= alu_out[DATA_W-1:0];
            result_hi_q <= '0;
            zf_q        <= (alu_out[DATA_W-1:0] == '0);
            cf_q        <= alu_out[DATA_W+1];
            nf_q        <= alu_out[DATA_W-1];
            vf_q        <= alu_out[DATA_W];
        end else if (wb_mul) begin
            result_q    <= mul_prod[DATA_W-1:0];
            result_hi_q <= mul_prod[2*DATA_W-1:DATA_W];
            zf_q        <= (mul_prod == '0);
            cf_q        <= (mul_prod[2*DATA_W-1:DATA_W] != '0);
            nf_q        <= mul_prod[2*DATA_W-1];
            vf_q        <= 1'b0;
        end
    end

    alu_mul8 u_mul (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .load_i      (mul_load),
        .step_i      (mul_step),
        .a_i         (opa_i),
        .b_i         (opb_i),
        .prod_next_o (mul_prod),
        .last_o      (mul_last)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_WB);
    assign wb_we_o     = (state_q == ST_WB);
    assign wb_wa_o     = dest_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zf_o        = zf_q;
    assign cf_o        = cf_q;
    assign nf_o        = nf_q;
    assign vf_o        = vf_q;

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios plus randomized traffic, each cycle
// compared against a transaction-level reference model.
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [2:0] op_i;
    logic [7:0] opa_i;
    logic [7:0] opb_i;
    logic [7:0] cin_bus_i;
    logic [1:0] dest_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] result_o;
    logic [7:0] result_hi_o;
    logic       zf_o;
    logic       cf_o;
    logic       nf_o;
    logic       vf_o;
    logic       wb_we_o;
    logic [1:0] wb_wa_o;

    always #5 clk = ~clk;

    alu_exec #(.DATA_W(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .opa_i       (opa_i),
        .opb_i       (opb_i),
        .cin_bus_i   (cin_bus_i),
        .dest_i      (dest_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .result_hi_o (result_hi_o),
        .zf_o        (zf_o),
        .cf_o        (cf_o),
        .nf_o        (nf_o),
        .vf_o        (vf_o),
        .wb_we_o     (wb_we_o),
        .wb_wa_o     (wb_wa_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edge counter, pending op and its write-back edge.
    int edge_no = 0;
    bit pend    = 1'b0;
    int wb_edge = 0;
    int pr_res, pr_hi;
    bit pr_zf, pr_cf, pr_nf, pr_vf;
    int e_res = 0, e_hi = 0, e_wa = 0;
    bit e_zf = 0, e_cf = 0, e_nf = 0, e_vf = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Expected outcome of one operation from plain integer arithmetic.
    task automatic model_compute(input int op, input int a, input int b, input int c);
        int s;
        int p;
        pr_hi = 0;
        pr_cf = 1'b0;
        pr_vf = 1'b0;
        case (op)
            0: begin
                s = a + b + c;
                pr_res = s & 255;
                pr_cf = (s > 255);
                s = to_signed8(a) + to_signed8(b) + c;
                pr_vf = (s > 127) || (s < -128);
            end
            1: begin
                s = a - b - c;
                pr_res = s & 255;
                pr_cf = (s < 0);
                s = to_signed8(a) - to_signed8(b) - c;
                pr_vf = (s > 127) || (s < -128);
            end
            2: pr_res = a & b;
            3: pr_res = a | b;
            4: pr_res = a ^ b;
            5: begin
                pr_res = (a * 2 + c) % 256;
                pr_cf = (a >= 128);
            end
            6: begin
                pr_res = c * 128 + a / 2;
                pr_cf = (a % 2) == 1;
            end
            default: begin
                p = a * b;
                pr_res = p % 256;
                pr_hi = p / 256;
                pr_zf = (p == 0);
                pr_cf = (pr_hi != 0);
                pr_nf = (p >= 32768);
            end
        endcase
        if (op != 7) begin
            pr_zf = (pr_res == 0);
            pr_nf = (pr_res >= 128);
        end
    endtask

    // Advance the model by one rising edge with the inputs applied at that edge.
    task automatic model_edge(input bit rst, input bit st, input int op,
                              input int a, input int b, input int c, input int d);
        edge_no++;
        if (rst) begin
            pend = 1'b0;
            e_res = 0; e_hi = 0; e_wa = 0;
            e_zf = 0; e_cf = 0; e_nf = 0; e_vf = 0;
        end else begin
            if (st && (!pend || edge_no >= wb_edge + 2)) begin
                model_compute(op, a, b, c);
                e_wa = d;
                pend = 1'b1;
                wb_edge = edge_no + ((op == 7) ? 8 : 0);
            end
            if (pend && edge_no == wb_edge) begin
                e_res = pr_res; e_hi = pr_hi;
                e_zf = pr_zf; e_cf = pr_cf; e_nf = pr_nf; e_vf = pr_vf;
            end
        end
    endtask

    task automatic check_all();
        bit exp_busy;
        bit exp_wb;
        exp_busy = pend && (edge_no <= wb_edge);
        exp_wb   = pend && (edge_no == wb_edge);
        check_eq("busy",      16'(busy_o),      16'(exp_busy));
        check_eq("done",      16'(done_o),      16'(exp_wb));
        check_eq("wb_we",     16'(wb_we_o),     16'(exp_wb));
        check_eq("wb_wa",     16'(wb_wa_o),     16'(e_wa));
        check_eq("result",    16'(result_o),    16'(e_res));
        check_eq("result_hi", 16'(result_hi_o), 16'(e_hi));
        check_eq("zf",        16'(zf_o),        16'(e_zf));
        check_eq("cf",        16'(cf_o),        16'(e_cf));
        check_eq("nf",        16'(nf_o),        16'(e_nf));
        check_eq("vf",        16'(vf_o),        16'(e_vf));
    endtask

    // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
    task automatic step(input bit rst, input bit st, input int op, input int a,
                        input int b, input int cb, input int d);
        reset_i   = rst;
        start_i   = st;
        op_i      = 3'(op);
        opa_i     = 8'(a);
        opb_i     = 8'(b);
        cin_bus_i = 8'(cb);
        dest_i    = 2'(d);
        @(posedge clk);
        model_edge(rst, st, op, a, b, cb & 1, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, int'($urandom_range(7)), int'($urandom_range(255)),
                 int'($urandom_range(255)), 0, int'($urandom_range(3)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, a, b, cb, d;
        bit rst, st;

        // Reset, including a START that must lose to reset.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 0, 5, 6, 0, 3);
        idle(1);

        // ADD with signed overflow into the sign bit.
        step(1'b0, 1'b1, 0, 8'h7F, 8'h01, 8'h00, 2);
        check_eq("add_res",  16'(result_o), 16'h0080);
        check_eq("add_nfvf", 16'({nf_o, vf_o, cf_o, zf_o}), 16'b1100);
        check_eq("add_wb",   16'({wb_we_o, done_o, wb_wa_o}), 16'b1110);
        idle(1);

        // SUB with borrow in and borrow out.
        step(1'b0, 1'b1, 1, 8'h00, 8'h01, 8'hFF, 1);
        check_eq("sub_res",   16'(result_o), 16'h00FE);
        check_eq("sub_flags", 16'({nf_o, vf_o, cf_o, zf_o}), 16'b1010);
        idle(1);

        // MUL 0xFF*0xFF: eight multiply cycles then write-back.
        step(1'b0, 1'b1, 7, 8'hFF, 8'hFF, 8'hFF, 3);
        idle(8);
        check_eq("mul_res",   16'({result_hi_o, result_o}), 16'hFE01);
        check_eq("mul_flags", 16'({cf_o, zf_o, done_o, wb_we_o, busy_o}), 16'b10111);
        idle(1);
        check_eq("mul_hold",  16'({result_hi_o, result_o}), 16'hFE01);
        idle(1);

        // MUL interrupted: ignored ADD start, then reset mid-multiply.
        step(1'b0, 1'b1, 7, 8'h12, 8'h34, 8'h00, 1);
        idle(2);
        step(1'b0, 1'b1, 0, 8'h01, 8'h01, 8'h00, 2);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0);
        idle(10);

        // Back-to-back start requests: the one landing on write-back is dropped.
        step(1'b0, 1'b1, 5, 8'h81, 8'h00, 8'hFF, 0);
        check_eq("shl_res", 16'({result_o, 7'd0, cf_o}), 16'h0301);
        step(1'b0, 1'b1, 4, 8'h5A, 8'h5A, 8'h00, 3);
        step(1'b0, 1'b1, 4, 8'h5A, 8'h5A, 8'h00, 3);
        check_eq("xor_res", 16'({result_o, 6'd0, zf_o, cf_o}), 16'h0002);
        idle(1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(39) == 0);
            st  = ($urandom_range(2) != 0);
            op  = int'($urandom_range(7));
            a   = int'($urandom_range(255));
            b   = int'($urandom_range(255));
            cb  = ($urandom_range(1) == 0) ? 8'h00 : 8'hFF;
            d   = int'($urandom_range(3));
            if ($urandom_range(7) == 0) a = 8'h80;
            if ($urandom_range(7) == 0) b = 8'h00;
            step(rst, st, op, a, b, cb, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_exec

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: DATA_W, 8, operand/result width; only 8 is supported.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 START  in  1  request; sampled only when BUSY=0.
REQ-005 OP  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 OPA  in  8  operand A, driven from register-file OUTA.
REQ-007 OPB  in  8  operand B, driven from register-file OUTB.
REQ-008 CIN_BUS  in  8  constant bus from register-file OUTC (0x00/0xFF); bit 0 is carry-in.
REQ-009 DEST  in  2  write-back register address (0 A, 1 B, 2 C, 3 IX).
REQ-010 BUSY  out  1  high in every state except IDLE.
REQ-011 DONE  out  1  one-cycle pulse in WB state.
REQ-012 RESULT  out  8  registered result low byte; drives register-file IN.
REQ-013 RESULT_HI  out  8  MUL product high byte; 0x00 for other ops.
REQ-014 ZF, CF, NF, VF  out  1 each  registered flags.
REQ-015 WB_WE  out  1  register-file write enable (MRWE); high only in WB.
REQ-016 WB_WA  out  2  register-file write address (WA1:WA0) = captured DEST.

Function
REQ-017 FSM states IDLE, MUL, WB; IDLE->WB on accepted non-MUL START; IDLE->MUL on accepted MUL START; MUL->WB after 8th MUL cycle; WB->IDLE unconditionally.
REQ-018 Accept at edge N when START=1 and state IDLE: OPA, OPB, CIN_BUS[0], OP, DEST captured.
REQ-019 Non-MUL latency: RESULT/flags valid, DONE=1, WB_WE=1 during cycle N+1.
REQ-020 MUL: shift-add, one multiplier bit per cycle, MUL state cycles N+1..N+8, WB in cycle N+9.
REQ-021 START while BUSY=1 (including WB) ignored, no side effects; max throughput one op per 2 cycles (non-MUL).
REQ-022 ADD: {CF,RESULT}=OPA+OPB+CIN; VF = signed overflow.
REQ-023 SUB: RESULT=OPA-OPB-CIN mod 256; CF=1 on borrow; VF = signed overflow.
REQ-024 AND/OR/XOR: bitwise; CF=0, VF=0.
REQ-025 SHL: RESULT={OPA[6:0],CIN}, CF=OPA[7]; SHR: RESULT={CIN,OPA[7:1]}, CF=OPA[0]; VF=0; OPB ignored.
REQ-026 MUL: unsigned 16-bit product {RESULT_HI,RESULT}; ZF=product==0; CF=RESULT_HI!=0; NF=product[15]; VF=0; CIN ignored.
REQ-027 Non-MUL: ZF=RESULT==0, NF=RESULT[7].
REQ-028 RESULT, RESULT_HI, flags update only on entry to WB; held until next WB or reset.
REQ-029 WB_WA holds captured DEST from accept until next accept.

Reset
REQ-030 RESET=1 at a rising edge: state IDLE; BUSY, DONE, WB_WE, RESULT, RESULT_HI, WB_WA, all flags = 0.
REQ-031 RESET dominates START at the same edge; no operation is accepted.
REQ-032 RESET mid-MUL or in WB aborts; no WB_WE pulse afterwards for the aborted op.

Structure
REQ-033 Shared package alu_pkg holds OP encodings and FSM state encoding.
REQ-034 Iterative multiplier SHALL be sub-module alu_mul8 (load, 8-step shift-add, 16-bit product); remainder flat.

Verification
REQ-035 ADD OPA=0x7F OPB=0x01 CIN_BUS=0x00 DEST=2 -> cycle N+1: RESULT=0x80, NF=1, VF=1, CF=0, ZF=0, WB_WE=1, WB_WA=2, DONE=1.
REQ-036 SUB OPA=0x00 OPB=0x01 CIN_BUS=0xFF -> RESULT=0xFE, CF=1, NF=1, VF=0, ZF=0 at N+1.
REQ-037 MUL OPA=0xFF OPB=0xFF -> BUSY=1 N+1..N+9; at N+9 RESULT=0x01, RESULT_HI=0xFE, CF=1, ZF=0, DONE=1, WB_WE=1.
REQ-038 MUL started, ADD START at N+3 -> ignored, MUL result unchanged; RESET at N+4 -> all outputs 0 at N+5, no WB_WE through N+12.
REQ-039 SHL OPA=0x81 CIN_BUS=0xFF -> RESULT=0x03, CF=1; then XOR OPA=OPB=0x5A -> RESULT=0x00, ZF=1, CF=0.
